// File: rtl/simd_enable_stack_if.sv
// ----------------------------------------------------------------------------
// simd_enable_stack_if
// Bus between the CU decode stage and the per-lane enable-mask stack.
//   op_valid  CU -> stack  op/cond valid this cycle
//   op        CU -> stack  000 nop, 001 push, 010 pop, 011 allen, 100 cond-clear
//   cond      CU -> stack  per-lane keep condition for cond-clear
//   en        stack -> CU  registered top-of-stack bit per lane
//   any_en    stack -> CU  OR of en, used to skip a jumpf block
//   depth     stack -> CU  current push depth
//   overflow  stack -> CU  sticky push-at-full flag
//   underflow stack -> CU  sticky pop-at-empty flag
//   halt      stack -> CU  sticky trap (only with ENSTK_TRAP_EN)
// Modports: master = CU side, slave = stack side.
// ----------------------------------------------------------------------------
interface simd_enable_stack_if #(
    parameter int NPROC = 2,
    parameter int DEPTH = 32
);
    localparam int DW = $clog2(DEPTH);

    logic             op_valid;
    logic [2:0]       op;
    logic [NPROC-1:0] cond;
    logic [NPROC-1:0] en;
    logic             any_en;
    logic [DW-1:0]    depth;
    logic             overflow;
    logic             underflow;
    logic             halt;

    modport master (
        output op_valid, op, cond,
        input  en, any_en, depth, overflow, underflow, halt
    );

    modport slave (
        input  op_valid, op, cond,
        output en, any_en, depth, overflow, underflow, halt
    );
endinterface

// File: rtl/simd_enable_stack.sv
// ----------------------------------------------------------------------------
// simd_enable_stack
// Per-lane enable-mask stack for the SIMD control unit. NPROC independent bit
// stacks of DEPTH entries share a single depth counter since control flow is
// uniform across lanes. Executes push/pop/allen/cond-clear ops from CU decode
// and drives each PE enable plus an any-enabled summary.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high; forces all lanes enabled, depth 0, flags 0
//   bus    simd_enable_stack_if.slave (op_valid/op/cond in; en/any_en/depth/
//          overflow/underflow/halt out)
// Configuration:
//   ENSTK_TRAP_EN  when defined, a push at full or pop at empty is dropped,
//                  the matching flag and halt are set, and all later ops are
//                  ignored until reset. Undefined: lossy shift, halt tied 0.
// ----------------------------------------------------------------------------
module simd_enable_stack #(
    parameter int NPROC = 2,
    parameter int DEPTH = 32
) (
    input logic             clk,
    input logic             reset,
    simd_enable_stack_if.slave bus
);
    localparam int DW = $clog2(DEPTH);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH - 1);

    localparam logic [2:0] OP_PUSH  = 3'b001;
    localparam logic [2:0] OP_POP   = 3'b010;
    localparam logic [2:0] OP_ALLEN = 3'b011;
    localparam logic [2:0] OP_COND  = 3'b100;

    // Bit 0 of each lane stack is the live enable (top of stack).
    logic [DEPTH-1:0] stk [NPROC];
    logic [DW-1:0]    depth_q;
    logic             overflow_q;
    logic             underflow_q;
    logic             halt_q;

    logic             at_full;
    logic             at_empty;
    logic             op_ok;

    assign at_full  = (depth_q == DEPTH_MAX);
    assign at_empty = (depth_q == '0);
    // halt_q is constant 0 in the lossy build, so this reduces to op_valid.
    assign op_ok    = bus.op_valid && !halt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NPROC; i++) stk[i] <= '1;
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (op_ok) begin
            case (bus.op)
                OP_PUSH: begin
                    if (at_full) overflow_q <= 1'b1;
                    else         depth_q    <= depth_q + 1'b1;
`ifdef ENSTK_TRAP_EN
                    if (!at_full)
`endif
                    // Duplicate the top; at full the bottom entry falls off.
                    for (int i = 0; i < NPROC; i++)
                        stk[i] <= {stk[i][DEPTH-2:0], stk[i][0]};
                end
                OP_POP: begin
                    if (at_empty) underflow_q <= 1'b1;
                    else          depth_q     <= depth_q - 1'b1;
`ifdef ENSTK_TRAP_EN
                    if (!at_empty)
`endif
                    // Refill the bottom with enabled so an underflowing pop
                    // eventually re-enables every lane.
                    for (int i = 0; i < NPROC; i++)
                        stk[i] <= {1'b1, stk[i][DEPTH-1:1]};
                end
                OP_ALLEN: begin
                    for (int i = 0; i < NPROC; i++) stk[i][0] <= 1'b1;
                end
                OP_COND: begin
                    for (int i = 0; i < NPROC; i++)
                        stk[i][0] <= stk[i][0] & bus.cond[i];
                end
                default: ;
            endcase
        end
    end

`ifdef ENSTK_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset)
            halt_q <= 1'b0;
        else if (op_ok && ((bus.op == OP_PUSH && at_full) ||
                           (bus.op == OP_POP  && at_empty)))
            halt_q <= 1'b1;
    end
`else
    assign halt_q = 1'b0;
`endif

    always_comb begin
        bus.en = '0;
        for (int i = 0; i < NPROC; i++) bus.en[i] = stk[i][0];
    end

    assign bus.any_en    = |bus.en;
    assign bus.depth     = depth_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
    assign bus.halt      = halt_q;
endmodule

// File: tb/tb_simd_enable_stack.sv
// ----------------------------------------------------------------------------
// tb_simd_enable_stack
// Directed bench for simd_enable_stack with NPROC=2, DEPTH=4. Expected values
// are hand-computed constants; the full/empty section selects its expectations
// on ENSTK_TRAP_EN.
// ----------------------------------------------------------------------------
module tb_simd_enable_stack;
    localparam logic [2:0] NOP   = 3'b000;
    localparam logic [2:0] PUSH  = 3'b001;
    localparam logic [2:0] POP   = 3'b010;
    localparam logic [2:0] ALLEN = 3'b011;
    localparam logic [2:0] COND  = 3'b100;
    localparam logic [2:0] RSVD  = 3'b101;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    simd_enable_stack_if #(.NPROC(2), .DEPTH(4)) bus ();

    simd_enable_stack #(.NPROC(2), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One op presented for exactly one rising edge; outputs sampled 1ns later.
    task automatic apply(input logic [2:0] o, input logic [1:0] c);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op       = o;
        bus.cond     = c;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        bus.op       = NOP;
        bus.cond     = 2'b11;
    endtask

    task automatic do_reset(input logic with_push);
        @(negedge clk);
        reset        = 1'b1;
        bus.op_valid = with_push;
        bus.op       = with_push ? PUSH : NOP;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.op_valid = 1'b0;
        bus.op       = NOP;
    endtask

    task automatic check_state(input string tag, input logic [1:0] en, input logic [1:0] dep,
                               input logic ovf, input logic unf, input logic hlt);
        check({tag, ".en"},    32'(bus.en),        32'(en));
        check({tag, ".any"},   32'(bus.any_en),    32'(|en));
        check({tag, ".depth"}, 32'(bus.depth),     32'(dep));
        check({tag, ".ovf"},   32'(bus.overflow),  32'(ovf));
        check({tag, ".unf"},   32'(bus.underflow), 32'(unf));
        check({tag, ".halt"},  32'(bus.halt),      32'(hlt));
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        bus.op_valid = 1'b0;
        bus.op       = NOP;
        bus.cond     = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_state("reset", 2'b11, 2'd0, 1'b0, 1'b0, 1'b0);

        // Basic push / cond / pop.
        apply(PUSH, 2'b11);  check_state("t1_push", 2'b11, 2'd1, 0, 0, 0);
        apply(COND, 2'b01);  check_state("t1_cond", 2'b01, 2'd1, 0, 0, 0);
        apply(POP,  2'b11);  check_state("t1_pop",  2'b11, 2'd0, 0, 0, 0);

        // Disable all at depth 0, then allen.
        apply(COND, 2'b00);  check_state("t2_cond",  2'b00, 2'd0, 0, 0, 0);
        apply(ALLEN, 2'b11); check_state("t2_allen", 2'b11, 2'd0, 0, 0, 0);

        // cond is ignored without op_valid; reserved op changes nothing.
        @(negedge clk);
        bus.op   = COND;
        bus.cond = 2'b00;
        @(posedge clk);
        #1;
        bus.op   = NOP;
        bus.cond = 2'b11;
        check_state("noval", 2'b11, 2'd0, 0, 0, 0);
        apply(RSVD, 2'b00);  check_state("rsvd", 2'b11, 2'd0, 0, 0, 0);

        // Nesting.
        apply(PUSH, 2'b11);
        apply(COND, 2'b01);  check_state("t3_c1", 2'b01, 2'd1, 0, 0, 0);
        apply(PUSH, 2'b11);  check_state("t3_p2", 2'b01, 2'd2, 0, 0, 0);
        apply(COND, 2'b00);  check_state("t3_c2", 2'b00, 2'd2, 0, 0, 0);
        apply(POP,  2'b11);  check_state("t3_o1", 2'b01, 2'd1, 0, 0, 0);
        apply(POP,  2'b11);  check_state("t3_o2", 2'b11, 2'd0, 0, 0, 0);

        // Full / empty. Lane 0 disabled first so the lost bottom entry shows.
        apply(COND, 2'b10);
        apply(PUSH, 2'b11);
        apply(PUSH, 2'b11);
        apply(PUSH, 2'b11);  check_state("t4_d3", 2'b10, 2'd3, 0, 0, 0);
        apply(PUSH, 2'b11);
`ifdef ENSTK_TRAP_EN
        check_state("t5_ovf",   2'b10, 2'd3, 1, 0, 1);
        apply(POP,   2'b11);  check_state("t5_pop",   2'b10, 2'd3, 1, 0, 1);
        apply(ALLEN, 2'b11);  check_state("t5_allen", 2'b10, 2'd3, 1, 0, 1);
        do_reset(1'b0);       check_state("t5_rst",   2'b11, 2'd0, 0, 0, 0);
`else
        check_state("t4_ovf", 2'b10, 2'd3, 1, 0, 0);
        apply(POP, 2'b11);
        apply(POP, 2'b11);
        apply(POP, 2'b11);    check_state("t4_d0",  2'b10, 2'd0, 1, 0, 0);
        apply(POP, 2'b11);    check_state("t4_unf", 2'b11, 2'd0, 1, 1, 0);
        do_reset(1'b0);       check_state("t4_rst", 2'b11, 2'd0, 0, 0, 0);
`endif

        // Reset wins over a concurrent push at depth 2.
        apply(PUSH, 2'b11);
        apply(COND, 2'b00);
        apply(PUSH, 2'b11);  check_state("t6_pre", 2'b00, 2'd2, 0, 0, 0);
        do_reset(1'b1);      check_state("t6_rst", 2'b11, 2'd0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
